vga_pattern_generator: RTL and testbench

VGA_PATTERN_GENERATOR -- requirements
Module: vga_pattern_generator

---
 rtl/vga_pattern_generator_if.sv | 26 ++
 rtl/vga_pattern_generator.sv | 174 +++++++++++++++++
 tb/tb_vga_pattern_generator.sv | 181 ++++++++++++++++++
 3 files changed

// File: rtl/vga_pattern_generator_if.sv
// Pixel-side bundle of the VGA pattern generator: timing-controller positions
// and syncs in, colour and delayed syncs out.
interface vga_pattern_generator_if #(
    parameter int COUNTER_SIZE = 11
);
    logic [COUNTER_SIZE-1:0] counter_in_hsync;
    logic [COUNTER_SIZE-1:0] counter_in_vsync;
    logic                    h_sync_in;
    logic                    v_sync_in;
    logic [3:0]              red;
    logic [3:0]              green;
    logic [3:0]              blue;
    logic                    h_sync_out;
    logic                    v_sync_out;
    logic [1:0]              pattern_sel;

    modport master (
        output counter_in_hsync, counter_in_vsync, h_sync_in, v_sync_in,
        input  red, green, blue, h_sync_out, v_sync_out, pattern_sel
    );

    modport slave (
        input  counter_in_hsync, counter_in_vsync, h_sync_in, v_sync_in,
        output red, green, blue, h_sync_out, v_sync_out, pattern_sel
    );
endinterface

// File: rtl/vga_pattern_generator.sv
// Two-stage VGA test-pattern generator cycling four patterns every FRAMES_PER_PATTERN frames.
// Optional white frame border enabled by defining VGA_PATGEN_BORDER_EN.
module vga_pattern_generator #(
    parameter logic [10:0] THRESHOLD_HSYNC    = 11'd1024,
    parameter logic [10:0] THRESHOLD_VSYNC    = 11'd768,
    parameter int          COUNTER_SIZE       = 11,
    parameter int          FRAMES_PER_PATTERN = 60
) (
    input  logic                  control_clock,
    input  logic                  control_reset_n,
    vga_pattern_generator_if.slave bus
);

    typedef enum logic [1:0] {
        COLOR_BARS = 2'd0,
        GRID       = 2'd1,
        GRADIENT   = 2'd2,
        CHECKER    = 2'd3
    } pattern_t;

    // Patterns only look at the low 10 position bits; out-of-frame values are blanked by the active flag.
    localparam int                      PIX_W      = 10;
    localparam logic [COUNTER_SIZE-1:0] H_LIM      = COUNTER_SIZE'(THRESHOLD_HSYNC);
    localparam logic [COUNTER_SIZE-1:0] V_LIM      = COUNTER_SIZE'(THRESHOLD_VSYNC);
    localparam logic [COUNTER_SIZE-1:0] POS_ZERO   = {COUNTER_SIZE{1'b0}};
    localparam logic [7:0]              FRAME_LAST = 8'(FRAMES_PER_PATTERN - 1);

    function automatic logic [11:0] pattern_colour(
        input pattern_t         pat,
        input logic [PIX_W-1:0] h,
        input logic [PIX_W-1:0] v
    );
        logic [11:0] c;
        case (pat)
            COLOR_BARS: c = {{4{~h[9]}}, {4{~h[8]}}, {4{~h[7]}}};
            GRID:       c = ((h[4:0] == 5'd0) || (v[4:0] == 5'd0)) ? 12'hFFF : 12'h000;
            GRADIENT:   c = {h[9:6], v[9:6], 4'h0};
            CHECKER:    c = (h[5] ^ v[5]) ? 12'hFFF : 12'h000;
            default:    c = 12'h000;
        endcase
        return c;
    endfunction

    pattern_t         pattern_r;
    pattern_t         pattern_next_s;
    logic [7:0]       frame_cnt_r;
    logic [7:0]       frame_cnt_next_s;
    logic             prev_nonzero_r;
    logic             origin_s;
    logic             boundary_s;
    logic             active_s;

    logic [PIX_W-1:0] h1_r;
    logic [PIX_W-1:0] v1_r;
    logic             hs1_r;
    logic             vs1_r;
    logic             active1_r;

    logic [11:0]      colour_s;
    logic [3:0]       red_r;
    logic [3:0]       green_r;
    logic [3:0]       blue_r;
    logic             hs2_r;
    logic             vs2_r;
    logic [1:0]       pattern_sel_r;

    assign origin_s   = (bus.counter_in_hsync == POS_ZERO) && (bus.counter_in_vsync == POS_ZERO);
    assign boundary_s = origin_s && prev_nonzero_r;
    assign active_s   = (bus.counter_in_hsync < H_LIM) && (bus.counter_in_vsync < V_LIM);

`ifdef VGA_PATGEN_BORDER_EN
    localparam logic [PIX_W-1:0] H_LAST = PIX_W'(THRESHOLD_HSYNC - 11'd1);
    localparam logic [PIX_W-1:0] V_LAST = PIX_W'(THRESHOLD_VSYNC - 11'd1);
    logic border_s;
    assign border_s = (h1_r == {PIX_W{1'b0}}) || (h1_r == H_LAST) ||
                      (v1_r == {PIX_W{1'b0}}) || (v1_r == V_LAST);
`endif

    // Stage 1: capture position, syncs, active flag and the origin history.
    always_ff @(posedge control_clock or negedge control_reset_n) begin
        if (!control_reset_n) begin
            h1_r           <= {PIX_W{1'b0}};
            v1_r           <= {PIX_W{1'b0}};
            hs1_r          <= 1'b0;
            vs1_r          <= 1'b0;
            active1_r      <= 1'b0;
            prev_nonzero_r <= 1'b0;
        end else begin
            h1_r           <= bus.counter_in_hsync[PIX_W-1:0];
            v1_r           <= bus.counter_in_vsync[PIX_W-1:0];
            hs1_r          <= bus.h_sync_in;
            vs1_r          <= bus.v_sync_in;
            active1_r      <= active_s;
            prev_nonzero_r <= ~origin_s;
        end
    end

    // Pattern/frame-counter state register; updates on the same edge that captures the boundary pixel.
    always_ff @(posedge control_clock or negedge control_reset_n) begin
        if (!control_reset_n) begin
            pattern_r   <= COLOR_BARS;
            frame_cnt_r <= 8'd0;
        end else begin
            pattern_r   <= pattern_next_s;
            frame_cnt_r <= frame_cnt_next_s;
        end
    end

    // Next pattern and frame count, evaluated only on a frame boundary.
    always_comb begin
        pattern_next_s   = pattern_r;
        frame_cnt_next_s = frame_cnt_r;
        if (boundary_s) begin
            if (frame_cnt_r == FRAME_LAST) begin
                frame_cnt_next_s = 8'd0;
                case (pattern_r)
                    COLOR_BARS: pattern_next_s = GRID;
                    GRID:       pattern_next_s = GRADIENT;
                    GRADIENT:   pattern_next_s = CHECKER;
                    CHECKER:    pattern_next_s = COLOR_BARS;
                    default:    pattern_next_s = COLOR_BARS;
                endcase
            end else begin
                frame_cnt_next_s = frame_cnt_r + 8'd1;
            end
        end else begin
            pattern_next_s   = pattern_r;
            frame_cnt_next_s = frame_cnt_r;
        end
    end

    // Colour for the stage-1 pixel: blank outside the frame, border (if built in) above every pattern.
    always_comb begin
        colour_s = 12'h000;
        if (!active1_r) begin
            colour_s = 12'h000;
        end
`ifdef VGA_PATGEN_BORDER_EN
        else if (border_s) begin
            colour_s = 12'hFFF;
        end
`endif
        else begin
            colour_s = pattern_colour(pattern_r, h1_r, v1_r);
        end
    end

    // Stage 2: registered colour, syncs and pattern index, all aligned to the same pixel.
    always_ff @(posedge control_clock or negedge control_reset_n) begin
        if (!control_reset_n) begin
            red_r         <= 4'h0;
            green_r       <= 4'h0;
            blue_r        <= 4'h0;
            hs2_r         <= 1'b0;
            vs2_r         <= 1'b0;
            pattern_sel_r <= 2'd0;
        end else begin
            red_r         <= colour_s[11:8];
            green_r       <= colour_s[7:4];
            blue_r        <= colour_s[3:0];
            hs2_r         <= hs1_r;
            vs2_r         <= vs1_r;
            pattern_sel_r <= pattern_r;
        end
    end

    assign bus.red         = red_r;
    assign bus.green       = green_r;
    assign bus.blue        = blue_r;
    assign bus.h_sync_out  = hs2_r;
    assign bus.v_sync_out  = vs2_r;
    assign bus.pattern_sel = pattern_sel_r;

endmodule

// File: tb/tb_vga_pattern_generator.sv
// Scoreboard bench for vga_pattern_generator (FRAMES_PER_PATTERN=2, compressed frames).
module tb_vga_pattern_generator;

    logic control_clock = 1'b0;
    logic control_reset_n;
    int   cyc = 0;
    int   n_checks = 0;
    int   n_fail = 0;

    typedef struct {
        int          h;
        int          v;
        logic [11:0] rgb;
        logic        hs;
        logic        vs;
        logic [1:0]  pat;
        int          due;
    } item_t;

    item_t sb[$];
    item_t mon_e;

    vga_pattern_generator_if #(.COUNTER_SIZE(11)) vif ();

    vga_pattern_generator #(
        .THRESHOLD_HSYNC   (11'd1024),
        .THRESHOLD_VSYNC   (11'd768),
        .COUNTER_SIZE      (11),
        .FRAMES_PER_PATTERN(2)
    ) dut (
        .control_clock  (control_clock),
        .control_reset_n(control_reset_n),
        .bus            (vif.slave)
    );

    always #5 control_clock = ~control_clock;

    always @(posedge control_clock) cyc <= cyc + 1;

    task automatic check(input string name, input logic [11:0] act, input logic [11:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: actual %0h required %0h", name, act, exp);
        end
    endtask

    // Drive one pixel and queue the colour/syncs/pattern expected two cycles later.
    task automatic pix(input int h, input int v, input logic hs, input logic vs,
                       input logic [11:0] exp, input logic [1:0] pat);
        item_t it;
        @(negedge control_clock);
        vif.counter_in_hsync = 11'(h);
        vif.counter_in_vsync = 11'(v);
        vif.h_sync_in        = hs;
        vif.v_sync_in        = vs;
        it.h   = h;
        it.v   = v;
        it.rgb = exp;
`ifdef VGA_PATGEN_BORDER_EN
        if (h < 1024 && v < 768 && (h == 0 || h == 1023 || v == 0 || v == 767))
            it.rgb = 12'hFFF;
`endif
        it.hs  = hs;
        it.vs  = vs;
        it.pat = pat;
        it.due = cyc + 2;
        sb.push_back(it);
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_rgb"}, {vif.red, vif.green, vif.blue}, 12'h000);
        check({tag, "_hsync"}, {11'd0, vif.h_sync_out}, 12'h000);
        check({tag, "_vsync"}, {11'd0, vif.v_sync_out}, 12'h000);
        check({tag, "_pattern"}, {10'd0, vif.pattern_sel}, 12'h000);
    endtask

    // Monitor: compare DUT outputs against the scoreboard entry due this cycle.
    always @(negedge control_clock) begin
        if (sb.size() > 0 && sb[0].due == cyc) begin
            mon_e = sb.pop_front();
            check($sformatf("rgb(%0d,%0d)", mon_e.h, mon_e.v), {vif.red, vif.green, vif.blue}, mon_e.rgb);
            check($sformatf("hsync(%0d,%0d)", mon_e.h, mon_e.v), {11'd0, vif.h_sync_out}, {11'd0, mon_e.hs});
            check($sformatf("vsync(%0d,%0d)", mon_e.h, mon_e.v), {11'd0, vif.v_sync_out}, {11'd0, mon_e.vs});
            check($sformatf("pattern(%0d,%0d)", mon_e.h, mon_e.v), {10'd0, vif.pattern_sel}, {10'd0, mon_e.pat});
        end
    end

    initial begin
        control_reset_n      = 1'b0;
        vif.counter_in_hsync = 11'd0;
        vif.counter_in_vsync = 11'd0;
        vif.h_sync_in        = 1'b1;
        vif.v_sync_in        = 1'b1;
        repeat (3) @(negedge control_clock);
        check_all_zero("reset");
        vif.h_sync_in   = 1'b0;
        vif.v_sync_in   = 1'b0;
        control_reset_n = 1'b1;

        // Frame 0: colour bars; (0,0) right after reset is not a boundary
        pix(0, 0, 0, 0, 12'hFFF, 2'd0);
        pix(0, 10, 0, 0, 12'hFFF, 2'd0);
        pix(128, 10, 0, 0, 12'hFF0, 2'd0);
        pix(896, 10, 0, 0, 12'h000, 2'd0);
        pix(384, 10, 0, 0, 12'hF00, 2'd0);
        pix(1024, 10, 1, 0, 12'h000, 2'd0);
        pix(1025, 10, 0, 0, 12'h000, 2'd0);
        pix(5, 800, 0, 1, 12'h000, 2'd0);
        pix(0, 0, 0, 0, 12'hFFF, 2'd0);      // boundary 1
        pix(5, 5, 0, 0, 12'hFFF, 2'd0);
        pix(0, 0, 0, 0, 12'hFFF, 2'd1);      // boundary 2 -> GRID
        pix(1, 1, 0, 0, 12'h000, 2'd1);
        pix(32, 7, 0, 0, 12'hFFF, 2'd1);
        pix(33, 64, 0, 0, 12'hFFF, 2'd1);
        pix(33, 65, 0, 0, 12'h000, 2'd1);
        pix(0, 0, 0, 0, 12'hFFF, 2'd1);      // boundary 3
        pix(1, 1, 0, 0, 12'h000, 2'd1);
        pix(0, 0, 0, 0, 12'h000, 2'd2);      // boundary 4 -> GRADIENT
        pix(1023, 767, 0, 0, 12'hFB0, 2'd2);
        pix(0, 100, 0, 0, 12'h010, 2'd2);
        pix(64, 64, 0, 0, 12'h110, 2'd2);
        pix(1024, 767, 0, 0, 12'h000, 2'd2);
        pix(0, 0, 0, 0, 12'h000, 2'd2);      // boundary 5
        pix(640, 320, 0, 0, 12'hA50, 2'd2);
        pix(0, 0, 0, 0, 12'h000, 2'd3);      // boundary 6 -> CHECKER
        pix(32, 0, 0, 0, 12'hFFF, 2'd3);
        pix(32, 32, 0, 0, 12'h000, 2'd3);
        pix(0, 32, 0, 0, 12'hFFF, 2'd3);
        pix(2047, 0, 0, 0, 12'h000, 2'd3);
        pix(0, 0, 0, 0, 12'h000, 2'd3);      // boundary 7
        pix(96, 0, 0, 0, 12'hFFF, 2'd3);
        pix(0, 0, 0, 0, 12'hFFF, 2'd0);      // boundary 8 -> COLOR_BARS
        pix(0, 0, 0, 0, 12'hFFF, 2'd0);      // held origin is not a boundary
        pix(1, 0, 0, 0, 12'hFFF, 2'd0);
        pix(0, 0, 0, 0, 12'hFFF, 2'd0);      // boundary 9
        pix(0, 0, 0, 0, 12'hFFF, 2'd0);
        pix(2, 3, 0, 0, 12'hFFF, 2'd0);
        pix(0, 0, 0, 0, 12'hFFF, 2'd1);      // boundary 10 -> GRID
        pix(1, 1, 0, 0, 12'h000, 2'd1);
        pix(0, 0, 0, 0, 12'hFFF, 2'd1);      // boundary 11
        pix(1, 1, 0, 0, 12'h000, 2'd1);
        pix(0, 0, 0, 0, 12'h000, 2'd2);      // boundary 12 -> GRADIENT
        pix(64, 64, 0, 0, 12'h110, 2'd2);
        pix(0, 0, 0, 0, 12'h000, 2'd2);      // boundary 13, frame counter now 1
        pix(640, 320, 1, 1, 12'hA50, 2'd2);
        pix(300, 300, 0, 0, 12'h440, 2'd2);
        pix(301, 300, 0, 0, 12'h440, 2'd2);  // (640,320) is on the outputs now

        // Mid-frame reset: outputs clear at once, pending pixels are discarded
        #2;
        control_reset_n = 1'b0;
        #1;
        sb.delete();
        check_all_zero("midreset");
        vif.counter_in_hsync = 11'd0;
        vif.counter_in_vsync = 11'd0;
        repeat (2) @(negedge control_clock);
        check_all_zero("midreset_hold");
        control_reset_n = 1'b1;

        // Restart at COLOR_BARS; two full boundaries needed before GRID
        pix(10, 10, 0, 0, 12'hFFF, 2'd0);
        pix(0, 0, 0, 0, 12'hFFF, 2'd0);
        pix(1, 0, 0, 0, 12'hFFF, 2'd0);
        pix(0, 0, 0, 0, 12'hFFF, 2'd1);
        pix(1, 1, 0, 0, 12'h000, 2'd1);

        for (int i = 0; i < 10 && sb.size() > 0; i++) @(negedge control_clock);
        #1;
        n_checks++;
        if (sb.size() != 0) begin
            n_fail++;
            $display("FAIL drain: actual %0d pending required 0", sb.size());
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
